// File: rtl/snes_pad_responder.sv
// Device-side SNES pad emulator: answers latch/pulse pins with an active-low, LSB-first serial button word.
// Optional watchdog that abandons a stalled frame is enabled by defining PAD_TIMEOUT_EN.
module snes_pad_responder #(
    parameter int   NUM_BITS = 16,
    parameter logic FILL_BIT = 1'b0,
    parameter int   TIMEOUT  = 4096
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_BITS-1:0] buttons,
    input  logic                latch_in,
    input  logic                pulse_in,
    output logic                data_out,
    output logic                busy,
    output logic [5:0]          bit_index,
    output logic                frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        LATCHED,
        SHIFTING,
        DONE
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_BITS - 1);
    localparam logic [5:0] FULL_IDX = 6'(NUM_BITS);

    if (NUM_BITS < 1 || NUM_BITS > 32 || TIMEOUT < 1 || TIMEOUT > 8191) begin : g_param_check
        $error("snes_pad_responder: NUM_BITS must be 1..32 and TIMEOUT 1..8191");
    end

    state_t              state;
    logic [NUM_BITS-1:0] sr;
    logic [NUM_BITS-1:0] sr_next;
    logic                latch_meta, latch_sync, latch_prev;
    logic                pulse_meta, pulse_sync, pulse_prev;
    logic                latch_rise, latch_fall, pulse_rise;
    logic                timed_out;

    // Two flops for metastability, a third to remember the previous level for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            latch_meta <= 1'b0;
            latch_sync <= 1'b0;
            latch_prev <= 1'b0;
            pulse_meta <= 1'b0;
            pulse_sync <= 1'b0;
            pulse_prev <= 1'b0;
        end else begin
            latch_meta <= latch_in;
            latch_sync <= latch_meta;
            latch_prev <= latch_sync;
            pulse_meta <= pulse_in;
            pulse_sync <= pulse_meta;
            pulse_prev <= pulse_sync;
        end
    end

    assign latch_rise = latch_sync & ~latch_prev;
    assign latch_fall = ~latch_sync & latch_prev;
    assign pulse_rise = pulse_sync & ~pulse_prev;
    assign sr_next    = sr >> 1;

`ifdef PAD_TIMEOUT_EN
    logic [12:0] wdog;
    logic        any_edge;

    assign any_edge  = (latch_sync ^ latch_prev) | (pulse_sync ^ pulse_prev);
    assign timed_out = (state == LATCHED || state == SHIFTING) && !any_edge
                       && (wdog == 13'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            wdog <= '0;
        end else if (any_edge) begin
            wdog <= '0;
        end else if (state == LATCHED || state == SHIFTING) begin
            wdog <= wdog + 13'd1;
        end else begin
            wdog <= '0;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    // A latch rise wins over everything else, so a pulse in the same cycle never shifts.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            sr         <= '0;
            data_out   <= 1'b1;
            busy       <= 1'b0;
            bit_index  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (latch_rise) begin
                state     <= LATCHED;
                sr        <= buttons;
                data_out  <= ~buttons[0];
                bit_index <= '0;
                busy      <= 1'b1;
            end else if (timed_out) begin
                state     <= IDLE;
                data_out  <= 1'b1;
                busy      <= 1'b0;
                bit_index <= '0;
            end else begin
                case (state)
                    LATCHED: begin
                        if (latch_fall) begin
                            state <= SHIFTING;
                        end else begin
                            sr       <= buttons;
                            data_out <= ~buttons[0];
                        end
                    end
                    SHIFTING: begin
                        if (pulse_rise) begin
                            sr <= sr_next;
                            if (bit_index == LAST_IDX) begin
                                state      <= DONE;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                                data_out   <= FILL_BIT;
                                bit_index  <= FULL_IDX;
                            end else begin
                                data_out  <= ~sr_next[0];
                                bit_index <= bit_index + 6'd1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/snes_pad_responder.md
Name: snes_pad_responder

Overview:
- Device-side end of the serial game-controller link that the MMIO controller poller drives: responds to latch/clock pulses on gpioOutput and returns one serial data bit per pulse on a gpio pin.
- Replaces a physical pad on the bench and in loopback builds. The button word comes from switches or a test driver.
- Electrical format matches a standard SNES pad: data is active-low, bit 0 is sent first.

Parameters:
- NUM_BITS, 16, bits per frame; legal range 1..32.
- FILL_BIT, 1'b0, electrical level driven after all NUM_BITS bits have been sent (0 = "pressed", as on a real pad).
- TIMEOUT, 4096, clock cycles without a pulse edge before the frame is abandoned (used only when PAD_TIMEOUT_EN is defined).

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- buttons, input, NUM_BITS, logical button state (1 = pressed); sampled only at latch.
- latch_in, input, 1, asynchronous latch pin from the poller; active-high.
- pulse_in, input, 1, asynchronous shift-clock pin from the poller; active on its rising edge.
- data_out, output, 1, serial data pin to the poller; active-low.
- busy, output, 1, high while a frame is latched or shifting.
- bit_index, output, 6, index of the bit currently on data_out.
- frame_done, output, 1, one-cycle pulse when the last bit has been shifted past.

Behaviour:
- One clock; reset is synchronous and active-high. The port names are clock and reset.
- Reset values: data_out=1, busy=0, bit_index=0, frame_done=0, state=IDLE. All synchronizer flops are cleared to 0.
- Input conditioning:
  - latch_in and pulse_in each pass through a 2-flop synchronizer, then a third flop for edge detection.
  - A pin change sampled at clock edge k is acted on at edge k+2; the register output is visible after edge k+2.
- Shift register sr[NUM_BITS-1:0]:
  - data_out = ~sr[0] while bits remain, otherwise FILL_BIT.
  - In IDLE, data_out=1.
- State machine:
  - IDLE: on synchronized latch rise → LATCHED. In the same cycle: sr<=buttons, bit_index<=0, busy<=1.
  - LATCHED: while latch is high, sr<=buttons every cycle, so the value taken is the last one before latch falls. Pulse edges are ignored. On latch fall → SHIFTING.
  - SHIFTING, on each pulse rise:
    - sr<=sr>>1 and bit_index<=bit_index+1.
    - When bit_index==NUM_BITS-1 → DONE, frame_done=1 for one cycle, and data_out goes to FILL_BIT.
  - DONE: further pulses are ignored; bit_index saturates at NUM_BITS and data_out stays FILL_BIT. A latch rise → LATCHED.
- Simultaneous events:
  - A latch rise in any state takes priority over a pulse edge in the same cycle: reload, bit_index=0, go to LATCHED.
  - A pulse rise while latch is high is discarded.
- Mid-frame re-latch: a latch rise in SHIFTING aborts the frame with no frame_done and restarts it.
- busy: 1 in LATCHED and SHIFTING; 0 in IDLE and DONE.
- Reset mid-frame: returns to IDLE on the next edge with data_out=1; a latch edge in progress is lost.
- buttons changes outside LATCHED have no effect on the frame in progress.

Optional Feature:
- Macro PAD_TIMEOUT_EN.
- When defined:
  - A 13-bit watchdog counter clears on every latch or pulse edge and counts in LATCHED and SHIFTING.
  - On reaching TIMEOUT the block returns to IDLE: data_out=1, busy=0, no frame_done.
  - Latch held high past TIMEOUT also times out.
- When undefined: no counter exists, and the block waits indefinitely in LATCHED or SHIFTING.

Test Plan:
- Reset: assert reset 2 cycles → data_out=1, busy=0, bit_index=0, frame_done=0.
- Normal frame: buttons=16'h0005, latch pulse 6 clocks, then 16 pulses of 4 clocks high / 4 clocks low.
  - Sampled data_out before each pulse: 0,1,0,1 then 1 × 12.
  - After the 16th pulse: data_out=0 (FILL_BIT), frame_done pulses once, busy=0.
- Extra pulses: 4 more pulses after DONE → data_out stays 0, bit_index=16, no frame_done.
- Re-latch mid-frame: buttons=16'hFFFF, 5 pulses, then latch with buttons=16'h0000 → bit_index=0, data_out=1, no frame_done. The next 16 bits all read 1.
- Latch/pulse same cycle: raise both pins on the same edge → state LATCHED, bit_index=0, no shift occurs.
- PAD_TIMEOUT_EN, TIMEOUT=64: latch then 3 pulses, then idle 70 clocks → back to IDLE by cycle 64 after the last edge, data_out=1, busy=0. Without the macro, busy stays 1.
